mem_access_sequencer: RTL

Sequences every data-memory transaction in the core: it accepts load/store requests from two requesters (CPU load/store unit and the program/debug loader), arbitrates between them round-robin, checks alignment, and drives the 3-bit control code, address and write strobe that feed the memory data handler and data RAM. It absorbs the synchronous RAM read latency and returns one registered acknowledge, with read data or an error flag, per transaction.

---
 rtl/mem_seq_pkg.sv | 55 +++++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/mem_access_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types, codes and helpers for the memory access sequencer
package mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_SWITCH = 2'b11;

  localparam logic [2:0] CTRL_IDLE    = 3'd0;
  localparam logic [2:0] CTRL_WR_BYTE = 3'd1;
  localparam logic [2:0] CTRL_WR_WORD = 3'd2;
  localparam logic [2:0] CTRL_WR_HALF = 3'd3;
  localparam logic [2:0] CTRL_RD_BYTE = 3'd4;
  localparam logic [2:0] CTRL_RD_HALF = 3'd5;
  localparam logic [2:0] CTRL_RD_WORD = 3'd6;
  localparam logic [2:0] CTRL_SWITCH  = 3'd7;

  // Misaligned halfword/word, or a store to the switch input, is rejected.
  function automatic logic is_invalid(input logic       write,
                                      input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    case (size)
      SZ_HALF:   return addr_lo[0];
      SZ_WORD:   return (addr_lo != 2'b00);
      SZ_SWITCH: return write;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ctrl_code(input logic write, input logic [1:0] size);
    if (write) begin
      case (size)
        SZ_BYTE: return CTRL_WR_BYTE;
        SZ_HALF: return CTRL_WR_HALF;
        SZ_WORD: return CTRL_WR_WORD;
        default: return CTRL_IDLE;
      endcase
    end else begin
      case (size)
        SZ_BYTE: return CTRL_RD_BYTE;
        SZ_HALF: return CTRL_RD_HALF;
        SZ_WORD: return CTRL_RD_WORD;
        default: return CTRL_SWITCH;
      endcase
    end
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with a last-grant pointer
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  // 0 = CPU granted last, 1 = loader granted last; reset value makes CPU win first.
  logic r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= o_grant[1];
    end
  end

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - arbitrates two requesters and sequences data-RAM transactions
import mem_seq_pkg::*;

module mem_access_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_req,
  input  logic [1:0]             i_req_write,
  input  logic [1:0][1:0]        i_req_size,
  input  logic [1:0][ADDR_W-1:0] i_req_addr,
  input  logic [1:0][31:0]       i_req_wdata,
  output logic [1:0]             o_ack,
  output logic                   o_err,
  output logic [31:0]            o_rdata,
  output logic                   o_busy,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic                   o_mem_we,
  output logic [2:0]             o_mem_ctrl,
  output logic [31:0]            o_mem_wdata,
  input  logic [31:0]            i_mem_rdata
);

  state_t r_state, w_next;

  logic              r_sel, r_write, r_inv;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_cnt;

  logic [1:0]        r_ack;
  logic              r_err, r_busy, r_mem_we;
  logic [31:0]       r_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [2:0]        r_mem_ctrl;

  logic [1:0]        w_grant;
  logic              w_take, w_gsel, w_ginv;
  logic              w_f_sel, w_f_write, w_f_inv;
  logic [1:0]        w_f_size;
  logic [ADDR_W-1:0] w_f_addr;
  logic [31:0]       w_f_wdata;
  logic              w_rd_done;

  logic [1:0]        w_ack_nxt;
  logic              w_err_nxt, w_we_nxt;
  logic [31:0]       w_rdata_nxt, w_wdata_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [2:0]        w_ctrl_nxt;

  assign w_take = (r_state == ST_IDLE) && (|i_req);

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_update (w_take),
    .o_grant  (w_grant)
  );

  assign w_gsel    = w_grant[1];
  assign w_ginv    = is_invalid(i_req_write[w_gsel], i_req_size[w_gsel], i_req_addr[w_gsel][1:0]);
  assign w_rd_done = (r_cnt == 3'(READ_LATENCY - 1));

  // Outputs are registered, so they are computed from the fields in force after the edge:
  // the incoming request when leaving IDLE, the latched copy otherwise.
  assign w_f_sel   = (r_state == ST_IDLE) ? w_gsel                    : r_sel;
  assign w_f_write = (r_state == ST_IDLE) ? i_req_write[w_gsel]       : r_write;
  assign w_f_size  = (r_state == ST_IDLE) ? i_req_size[w_gsel]        : r_size;
  assign w_f_addr  = (r_state == ST_IDLE) ? i_req_addr[w_gsel]        : r_addr;
  assign w_f_wdata = (r_state == ST_IDLE) ? i_req_wdata[w_gsel]       : r_wdata;
  assign w_f_inv   = (r_state == ST_IDLE) ? w_ginv                    : r_inv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (|i_req) w_next = w_ginv ? ST_RESP : ST_ACCESS;
      ST_ACCESS:    w_next = r_write ? ST_RESP : ST_READ_WAIT;
      ST_READ_WAIT: if (w_rd_done) w_next = ST_RESP;
      ST_RESP:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt   = 2'b00;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = 32'd0;
    w_we_nxt    = 1'b0;
    w_ctrl_nxt  = CTRL_IDLE;
    w_addr_nxt  = '0;
    w_wdata_nxt = 32'd0;
    case (w_next)
      ST_ACCESS, ST_READ_WAIT: begin
        w_ctrl_nxt  = ctrl_code(w_f_write, w_f_size);
        w_addr_nxt  = w_f_addr;
        w_wdata_nxt = w_f_wdata;
        w_we_nxt    = (w_next == ST_ACCESS) && w_f_write;
      end
      ST_RESP: begin
        w_ack_nxt   = w_f_sel ? 2'b10 : 2'b01;
        w_err_nxt   = w_f_inv;
        w_rdata_nxt = (r_state == ST_READ_WAIT) ? i_mem_rdata : 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel       <= 1'b0;
      r_write     <= 1'b0;
      r_inv       <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_cnt       <= 3'd0;
      r_ack       <= 2'b00;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_ctrl  <= CTRL_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      if (w_take) begin
        r_sel   <= w_gsel;
        r_write <= i_req_write[w_gsel];
        r_inv   <= w_ginv;
        r_size  <= i_req_size[w_gsel];
        r_addr  <= i_req_addr[w_gsel];
        r_wdata <= i_req_wdata[w_gsel];
      end
      r_cnt       <= (r_state == ST_READ_WAIT) ? r_cnt + 3'd1 : 3'd0;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= (w_next != ST_IDLE);
      r_mem_we    <= w_we_nxt;
      r_mem_ctrl  <= w_ctrl_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_mem_we    = r_mem_we;
  assign o_mem_ctrl  = r_mem_ctrl;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
